// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and constants; PARITY state exists only with UART_TX_PARITY_EN
package uart_pkg;
  localparam int DATA_BITS = 8;
  localparam int DEF_CLKS_PER_BIT = 434;
  localparam logic IDLE_LVL = 1'b1;
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter with one-cycle tick on the last clock of each period
module uart_baud_gen import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  logic [W-1:0] cnt;
  assign tick = en && cnt == LAST;
  // count 0..CLKS_PER_BIT-1 while enabled; clear restarts the period
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: 8N1 byte serialiser (LSB first); UART_TX_PARITY_EN adds an even-parity bit
module uart_tx_ctrl import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] txdw,
  input  logic       txstart,
  output logic       tx,
  output logic       txbusy,
  output logic       txdone
);
  state_t state;
  logic [DATA_BITS-1:0] shreg;
  logic [2:0] idx;
  logic tick;
  logic accept;
`ifdef UART_TX_PARITY_EN
  logic par;
`endif
  assign accept = state == IDLE && txstart;
  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk(clk),
    .rst(rst),
    .clr(accept),
    .en(state != IDLE),
    .tick(tick)
  );
  // frame FSM; tx/txbusy/txdone are registered and change on bit-period boundaries
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      idx <= '0;
      tx <= IDLE_LVL;
      txbusy <= 1'b0;
      txdone <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      txdone <= 1'b0;
      case (state)
        IDLE: if (txstart) begin
          shreg <= txdw;
          idx <= '0;
          state <= START;
          txbusy <= 1'b1;
          tx <= 1'b0;
`ifdef UART_TX_PARITY_EN
          par <= ^txdw;
`endif
        end
        START: if (tick) begin
          state <= DATA;
          tx <= shreg[0];
        end
        DATA: if (tick) begin
          if (idx == 3'(DATA_BITS - 1)) begin
            idx <= '0;
`ifdef UART_TX_PARITY_EN
            state <= PARITY;
            tx <= par;
`else
            state <= STOP;
            tx <= IDLE_LVL;
`endif
          end else begin
            shreg <= {1'b0, shreg[DATA_BITS-1:1]};
            idx <= idx + 1'b1;
            tx <= shreg[1];
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (tick) begin
          state <= STOP;
          tx <= IDLE_LVL;
        end
`endif
        STOP: if (tick) begin
          if (idx == 3'(STOP_BITS - 1)) begin
            state <= IDLE;
            txbusy <= 1'b0;
            txdone <= 1'b1;
          end else idx <= idx + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
